// File: rtl/lane_sram.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | lane_sram: byte-addressed single-port SRAM, per-lane enables, valid/ready.  |
// | Macro LANE_SRAM_UNALIGNED_EN enables two-cycle split of misaligned access.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module lane_sram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int LANES   = DATA_W / 8;
  localparam int OFFS_W  = $clog2(LANES);
  localparam int WADDR_W = ADDR_W - OFFS_W;
  localparam int WORDS   = 1 << WADDR_W;

  logic [WADDR_W-1:0]       req_word;
  logic [OFFS_W-1:0]        req_off;
  logic                     aligned;
  logic                     accept;

  // Unified single-port access: either the incoming request or the latched split half.
  logic                     in_split;
  logic                     cur_go;
  logic                     cur_we;
  logic [WADDR_W-1:0]       cur_word;
  logic [OFFS_W-1:0]        cur_off;
  logic [LANES-1:0]         cur_be;
  logic [LANES-1:0][7:0]    cur_wdata;

  logic [LANES-1:0][7:0]    rd_byte;
  logic [LANES-1:0][7:0]    rd_rot;
  logic [LANES-1:0][7:0]    rd_merge;
  logic [LANES-1:0][7:0]    split_part;

  logic                     done;
  logic                     done_read;
  logic                     done_err;

  assign req_word = req_addr[ADDR_W-1:OFFS_W];
  assign req_off  = req_addr[OFFS_W-1:0];
  assign aligned  = (req_off == '0);
  assign accept   = req_valid && req_ready;

`ifdef LANE_SRAM_UNALIGNED_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_nx;
  logic                  split_start;
  logic                  lat_we;
  logic [WADDR_W-1:0]    lat_word;
  logic [OFFS_W-1:0]     lat_off;
  logic [LANES-1:0]      lat_be;
  logic [LANES-1:0][7:0] lat_wdata;
  logic [LANES-1:0][7:0] lat_part;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept && !aligned) state_nx = ST_SPLIT;
      ST_SPLIT: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    in_split  = (state == ST_SPLIT);
  end

  assign split_start = accept && !aligned;

  // First-half read lanes are parked here until the second word is fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_word  <= '0;
      lat_off   <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      lat_part  <= '0;
    end else if (split_start) begin
      lat_we    <= req_we;
      lat_word  <= req_word;
      lat_off   <= req_off;
      lat_be    <= req_be;
      lat_wdata <= req_wdata;
      lat_part  <= rd_rot;
    end
  end

  assign cur_go     = accept || in_split;
  assign cur_we     = in_split ? lat_we    : req_we;
  assign cur_word   = in_split ? lat_word + WADDR_W'(1) : req_word;
  assign cur_off    = in_split ? lat_off   : req_off;
  assign cur_be     = in_split ? lat_be    : req_be;
  assign cur_wdata  = in_split ? lat_wdata : req_wdata;
  assign split_part = lat_part;

  assign done      = in_split || (accept && aligned);
  assign done_read = in_split ? !lat_we : !req_we;
  assign done_err  = 1'b0;
`else
  assign req_ready  = 1'b1;
  assign in_split   = 1'b0;
  assign cur_go     = accept && aligned;
  assign cur_we     = req_we;
  assign cur_word   = req_word;
  assign cur_off    = req_off;
  assign cur_be     = req_be;
  assign cur_wdata  = req_wdata;
  assign split_part = '0;

  // Misaligned requests are answered with an error and never touch storage.
  assign done      = accept;
  assign done_read = !req_we && aligned;
  assign done_err  = accept && !aligned;
`endif

  // Memory byte j carries lane (j - off); the first half owns bytes >= off, the second bytes < off.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    localparam logic [OFFS_W-1:0] J = OFFS_W'(j);

    logic [7:0]        bank [WORDS];
    logic [OFFS_W-1:0] wsrc;
    logic [OFFS_W-1:0] rsrc;
    logic              in_range;
    logic              wr_en;

    assign wsrc     = J - cur_off;
    assign rsrc     = J + cur_off;
    assign in_range = in_split ? (J < cur_off) : (J >= cur_off);
    assign wr_en    = cur_go && cur_we && in_range && cur_be[wsrc];

    always_ff @(posedge clk) begin
      if (wr_en) begin
        bank[cur_word] <= cur_wdata[wsrc];
      end
    end

    assign rd_byte[j]  = bank[cur_word];
    assign rd_rot[j]   = rd_byte[rsrc];
    assign rd_merge[j] = (in_split && (rsrc >= cur_off)) ? split_part[j] : rd_rot[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done;
      rsp_err   <= done_err;
      rsp_rdata <= (done && done_read) ? rd_merge : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lane_sram.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_lane_sram: directed and random traffic against a byte-array model.       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_lane_sram;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] last_rdata;
  logic [7:0]  model [65536];

  lane_sram #(.DATA_W(32), .ADDR_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: expected response derived from the byte model before it is updated.
  task automatic xact(input logic we, input logic [3:0] be, input logic [15:0] addr,
                      input logic [31:0] wd, input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          split;
    int          waits;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    waits = 0;
    while (req_ready !== 1'b1 && waits < 4) begin
      @(negedge clk);
      waits++;
    end
    chk({tag, " wait"}, 32'(waits), 32'd0);
    if (req_ready !== 1'b1) begin
      req_valid = 1'b0;
      return;
    end
    split   = (addr[1:0] != 2'd0);
    exp_err = 1'b0;
    exp_rd  = '0;
`ifndef LANE_SRAM_UNALIGNED_EN
    exp_err = split;
    split   = 1'b0;
    if (!exp_err) begin
`else
    begin
`endif
      for (int i = 0; i < 4; i++) exp_rd[8*i +: 8] = model[addr + 16'(i)];
      if (we) begin
        exp_rd = '0;
        for (int i = 0; i < 4; i++) if (be[i]) model[addr + 16'(i)] = wd[8*i +: 8];
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1) != 0;
    req_be    = 4'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = $urandom;
    if (split) begin
      chk({tag, " split ready"}, {31'd0, req_ready}, 32'd0);
      chk({tag, " split valid"}, {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk({tag, " ready back"}, {31'd0, req_ready}, 32'd1);
    end
    chk({tag, " valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    chk({tag, " rdata"}, rsp_rdata, exp_rd);
    last_rdata = rsp_rdata;
  endtask

  initial begin
    logic [15:0] a;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, req_ready}, 32'd1);
    chk("reset valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset err", {31'd0, rsp_err}, 32'd0);
    chk("reset rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Make every byte the tests touch known.
    for (int w = 0; w < 32; w++) xact(1'b1, 4'hF, 16'(w * 4), $urandom, "fill_lo");
    for (int w = 0; w < 32; w++) xact(1'b1, 4'hF, 16'(16'hFF80 + w * 4), $urandom, "fill_hi");

    xact(1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, "wr10");
    xact(1'b0, 4'h0, 16'h0010, 32'h0, "rd10");
    chk("rd10 const", last_rdata, 32'hDEADBEEF);

    xact(1'b1, 4'hF, 16'h0020, 32'h11223344, "wr20");
    xact(1'b1, 4'b0101, 16'h0020, 32'hAABBCCDD, "wr20be");
    xact(1'b0, 4'hF, 16'h0020, 32'h0, "rd20");
    chk("rd20 const", last_rdata, 32'h11BB33DD);

    xact(1'b1, 4'hF, 16'h0006, 32'hCAFEF00D, "wr06");
    xact(1'b0, 4'h0, 16'h0004, 32'h0, "rd04");
    xact(1'b0, 4'h0, 16'h0008, 32'h0, "rd08");
    xact(1'b0, 4'h0, 16'h0006, 32'h0, "rd06");
`ifdef LANE_SRAM_UNALIGNED_EN
    chk("rd06 const", last_rdata, 32'hCAFEF00D);
`endif

    xact(1'b1, 4'hF, 16'hFFFE, 32'h01020304, "wrFFFE");
    xact(1'b0, 4'h0, 16'h0000, 32'h0, "rd0000");
    xact(1'b0, 4'h0, 16'hFFFE, 32'h0, "rdFFFE");
`ifdef LANE_SRAM_UNALIGNED_EN
    chk("rdFFFE const", last_rdata, 32'h01020304);

    // Reset while the second half of a split write is pending.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_be    = 4'hF;
    req_addr  = 16'h0006;
    req_wdata = 32'h55667788;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rstsplit in split", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstsplit ready", {31'd0, req_ready}, 32'd1);
    chk("rstsplit valid", {31'd0, rsp_valid}, 32'd0);
    model[16'h0006] = 8'h88;
    model[16'h0007] = 8'h77;
    @(posedge clk);
    #1;
    chk("rstsplit no rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstsplit after", {31'd0, rsp_valid}, 32'd0);
    xact(1'b0, 4'h0, 16'h0006, 32'h0, "rstsplit rd06");
    xact(1'b0, 4'h0, 16'h0008, 32'h0, "rstsplit rd08");
`else
    xact(1'b0, 4'h0, 16'h0003, 32'h0, "err03");
    xact(1'b1, 4'hF, 16'h0006, 32'h99999999, "errwr06");
    xact(1'b0, 4'h0, 16'h0004, 32'h0, "after rd04");
    xact(1'b0, 4'h0, 16'h0008, 32'h0, "after rd08");
`endif

    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 1) != 0) ? 16'h0000 : 16'hFFC0;
      a = a + 16'($urandom_range(0, 63));
`ifndef LANE_SRAM_UNALIGNED_EN
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'd0;
`endif
      xact($urandom_range(0, 1) != 0, 4'($urandom), a, $urandom, "rand");
    end

    @(posedge clk);
    #1;
    chk("idle valid", {31'd0, rsp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
